// File: rtl/hit_timestamp_fifo.sv
// Purpose  : tags rise/fall/conflict hits with the coarse counter and inserts rollover markers into a show-ahead FIFO.
// Latency  : a hit is written at its own edge and appears on oData/oValid one cycle later.
// Backpres : valid/ready read port; when full, hits are dropped (counted), but a rollover marker waits until there is room.
//
// Ports:
//   iClk, iRst          clock, async active-low reset
//   iEn                 capture enable; low freezes the counter and ignores hits
//   iRise, iFall        single-cycle edge pulses
//   oData, oValid       head entry {type[1:0], timestamp}, valid while non-empty
//   iRdEn               consumer ready; a pop occurs on oValid && iRdEn
//   oFull, oOvf         FIFO full, sticky "something was dropped"
//   oDropCnt            saturating count of dropped hits
module hit_timestamp_fifo #(
    parameter int CNT_W = 16,
    parameter int DEPTH = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iRise,
    input  logic             iFall,
    output logic [CNT_W+1:0] oData,
    output logic             oValid,
    input  logic             iRdEn,
    output logic             oFull,
    output logic             oOvf,
    output logic [7:0]       oDropCnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [AW:0]      OCC_FULL = {1'b1, {AW{1'b0}}};

    logic [CNT_W-1:0] r_cnt;
    logic             r_roll_pend;
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_occ;
    logic             r_valid;
    logic             r_full;
    logic [DW-1:0]    r_dout;
    logic             r_ovf;
    logic [7:0]       r_drop_cnt;
    logic [DW-1:0]    r_mem [DEPTH];

    logic             w_hit;
    logic [1:0]       w_type;
    logic             w_mark_req;
    logic             w_pop;
    logic             w_space;
    logic             w_wr;
    logic             w_drop;
    logic             w_wrap;
    logic [DW-1:0]    w_wdata;
    logic [AW:0]      w_rd_ptr_nxt;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr_nxt;
    logic [DW-1:0]    w_head_nxt;
    logic [AW:0]      w_occ_nxt;

    assign w_hit      = iEn & (iRise | iFall);
    // Both pulses together encode as 2'b00; otherwise {fall, rise} gives 01/10.
    assign w_type     = (iRise & iFall) ? 2'b00 : {iFall, iRise};
    // Marker only takes a hit-free enabled cycle; hits always win the write slot.
    assign w_mark_req = iEn & r_roll_pend & ~w_hit;
    assign w_pop      = r_valid & iRdEn;
    // A full FIFO still accepts a write when the same cycle pops.
    assign w_space    = ~r_full | w_pop;
    assign w_wr       = (w_hit | w_mark_req) & w_space;
    assign w_drop     = w_hit & ~w_space;
    assign w_wrap     = iEn & (r_cnt == CNT_MAX);
    assign w_wdata    = w_hit ? {w_type, r_cnt} : {2'b11, {CNT_W{1'b0}}};

    assign w_rd_ptr_nxt  = r_rd_ptr + {{AW{1'b0}}, w_pop};
    assign w_wr_addr     = r_wr_ptr[AW-1:0];
    assign w_rd_addr_nxt = w_rd_ptr_nxt[AW-1:0];
    // The write address only equals the next head address when the entry being
    // written becomes the head (FIFO empty after this cycle's pop), so bypass it.
    assign w_head_nxt    = (w_wr && (w_wr_addr == w_rd_addr_nxt)) ? w_wdata
                                                                  : r_mem[w_rd_addr_nxt];

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_wr, w_pop})
            2'b10:   w_occ_nxt = r_occ + {{AW{1'b0}}, 1'b1};
            2'b01:   w_occ_nxt = r_occ - {{AW{1'b0}}, 1'b1};
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Storage has no reset: reset discards contents by clearing the pointers.
    always_ff @(posedge iClk) begin
        if (w_wr) begin
            r_mem[w_wr_addr] <= w_wdata;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_cnt       <= '0;
            r_roll_pend <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_valid     <= 1'b0;
            r_full      <= 1'b0;
            r_dout      <= '0;
            r_ovf       <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (iEn) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // A new wrap wins over clearing, so a wrap coinciding with the
            // marker write leaves a fresh marker pending.
            if (w_wrap) begin
                r_roll_pend <= 1'b1;
            end else if (w_mark_req && w_space) begin
                r_roll_pend <= 1'b0;
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_occ    <= w_occ_nxt;
            r_valid  <= (w_occ_nxt != '0);
            r_full   <= (w_occ_nxt == OCC_FULL);
            r_dout   <= w_head_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    assign oData    = r_dout;
    assign oValid   = r_valid;
    assign oFull    = r_full;
    assign oOvf     = r_ovf;
    assign oDropCnt = r_drop_cnt;

endmodule

// File: tb/tb_hit_timestamp_fifo.sv
// Purpose  : randomized and directed bench for hit_timestamp_fifo against a queue-based reference model.
// Latency  : the model state is committed 2 time units after each rising edge; the monitor samples on falling edges.
// Backpres : the monitor pops the expected-entry queue whenever the DUT shows oValid && iRdEn.
module tb_hit_timestamp_fifo;

    localparam int CW = 4;
    localparam int DP = 4;
    localparam int DW = CW + 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          iClk = 1'b0;
    logic          iRst = 1'b0;
    logic          iEn = 1'b0;
    logic          iRise = 1'b0;
    logic          iFall = 1'b0;
    logic          iRdEn = 1'b0;
    logic [DW-1:0] oData;
    logic          oValid;
    logic          oFull;
    logic          oOvf;
    logic [7:0]    oDropCnt;

    hit_timestamp_fifo #(.CNT_W(CW), .DEPTH(DP)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iEn      (iEn),
        .iRise    (iRise),
        .iFall    (iFall),
        .oData    (oData),
        .oValid   (oValid),
        .iRdEn    (iRdEn),
        .oFull    (oFull),
        .oOvf     (oOvf),
        .oDropCnt (oDropCnt)
    );

    always #5 iClk = ~iClk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;
    int            m_cnt = 0;
    int            m_occ = 0;
    int            m_drop = 0;
    bit            m_roll = 1'b0;
    bit            m_ovf = 1'b0;
    bit            mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares status flags against the model and checks every popped entry.
    always @(negedge iClk) begin
        if (mon_en) begin
            chk("valid", int'(oValid), int'(m_occ > 0));
            chk("full", int'(oFull), int'(m_occ == DP));
            chk("ovf", int'(oOvf), int'(m_ovf));
            chk("dropcnt", int'(oDropCnt), m_drop);
            if (oValid && iRdEn) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("pop_data", int'(oData), int'(mon_exp));
                end
            end
        end
    end

    // One clock cycle: drive inputs, then advance the reference model past the edge.
    task automatic step(input bit en, input bit rise, input bit fall, input bit rd);
        bit            pop;
        bit            hit;
        bit            mark;
        bit            space;
        bit            push;
        logic [1:0]    typ;
        logic [CW-1:0] ts;
        logic [DW-1:0] ent;
        iEn   = en;
        iRise = rise;
        iFall = fall;
        iRdEn = rd;
        pop   = rd && (m_occ > 0);
        hit   = en && (rise || fall);
        typ   = (rise && fall) ? 2'b00 : (rise ? 2'b01 : 2'b10);
        mark  = en && !hit && m_roll;
        space = (m_occ < DP) || pop;
        ts    = m_cnt[CW-1:0];
        push  = 1'b0;
        ent   = '0;
        if (hit && space) begin
            ent  = {typ, ts};
            push = 1'b1;
        end else if (mark && space) begin
            ent  = {2'b11, {CW{1'b0}}};
            push = 1'b1;
        end
        @(posedge iClk);
        #2;
        if (push) exp_q.push_back(ent);
        m_occ = m_occ + (push ? 1 : 0) - (pop ? 1 : 0);
        if (hit && !space) begin
            m_ovf  = 1'b1;
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
        if (mark && space) m_roll = 1'b0;
        if (en && m_cnt == CMAX) m_roll = 1'b1;
        if (en) m_cnt = (m_cnt + 1) % (CMAX + 1);
    endtask

    task automatic run_to(input int target, input bit rd);
        for (int k = 0; k < 40 && m_cnt != target; k++) step(1'b1, 1'b0, 1'b0, rd);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && m_occ > 0; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt  = 0;
        m_occ  = 0;
        m_drop = 0;
        m_roll = 1'b0;
        m_ovf  = 1'b0;
    endtask

    initial begin
        // Power-on reset values.
        #13;
        chk("rst_valid", int'(oValid), 0);
        chk("rst_full", int'(oFull), 0);
        chk("rst_ovf", int'(oOvf), 0);
        chk("rst_dropcnt", int'(oDropCnt), 0);
        chk("rst_data", int'(oData), 0);
        #4 iRst = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;

        // Single rise at cnt=5, then pop.
        run_to(5, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1_valid", int'(oValid), 1);
        chk("t1_data", int'(oData), 'h15);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_empty", int'(oValid), 0);

        // Rise, fall, conflict (marker from the wrap lands in between).
        run_to(10, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        run_to(14, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        run_to(4, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        drain();

        // Hits at 15 and 0 defer the marker to the next hit-free cycle.
        run_to(15, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_occ3", int'(oFull), 0);
        drain();
        // Four back-to-back hits across the wrap; marker follows the last one.
        run_to(14, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        drain();

        // Overflow: six hits into a depth-4 FIFO with no reads.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 3) chk("t4_full_after_4", int'(oFull), 1);
        end
        chk("t4_dropcnt", int'(oDropCnt), 2);
        chk("t4_ovf", int'(oOvf), 1);

        // Full with simultaneous read and write: accepted, no drop.
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_full", int'(oFull), 1);
        chk("t5_dropcnt", int'(oDropCnt), 2);
        drain();

        // Drop counter saturation.
        for (int i = 0; i < 304; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("sat_dropcnt", int'(oDropCnt), 255);
        drain();

        // Asynchronous reset with three entries queued and a marker pending.
        run_to(14, 1'b1);
        drain();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        mon_en = 1'b0;
        iEn = 1'b0; iRise = 1'b0; iFall = 1'b0; iRdEn = 1'b0;
        #2 iRst = 1'b0;
        #1;
        chk("arst_valid", int'(oValid), 0);
        chk("arst_full", int'(oFull), 0);
        chk("arst_ovf", int'(oOvf), 0);
        chk("arst_dropcnt", int'(oDropCnt), 0);
        chk("arst_data", int'(oData), 0);
        model_reset();
        #20 iRst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        run_to(2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_valid", int'(oValid), 1);
        chk("t6_data", int'(oData), 'h12);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_only_entry", int'(oValid), 0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            int  r;
            bit  en;
            en = ($urandom_range(0, 9) != 0);
            r  = $urandom_range(0, 5);
            step(en, (r == 1 || r == 3), (r == 2 || r == 3), ($urandom_range(0, 1) == 1));
        end
        drain();
        chk("final_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
